// File: rtl/i2s_pkg.sv
// i2s_pkg: constants shared by the I2S receiver and transmitter.
//   CH_LEFT / CH_RIGHT : lrclk level that selects each channel
//   BITSIZE_DEF        : default word width per channel
//   i2s_state_t        : receiver FSM state encoding (UNSYNC, RUN)
package i2s_pkg;

   localparam int unsigned BITSIZE_DEF = 32;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   typedef logic [0:0] i2s_state_t;
   localparam i2s_state_t UNSYNC = 1'b0;
   localparam i2s_state_t RUN    = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: two-flop synchronizer for one asynchronous pin, with an
// optional third flop for edge detection.
//   clk, rst  : system clock, synchronous active-high reset
//   din       : asynchronous input pin
//   sync      : synchronized level (second stage)
//   rise/fall : one-clk pulses on synchronized edges (EDGE_DET=1), else 0
module i2s_sync_edge #(
   parameter bit EDGE_DET = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = din;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign sync = s2_q;

   generate
      if (EDGE_DET) begin : g_edge
         logic s3_q, s3_d;

         always_comb s3_d = s2_q;

         always_ff @(posedge clk) begin
            if (rst) s3_q <= 1'b0;
            else     s3_q <= s3_d;
         end

         assign rise = s2_q & ~s3_q;
         assign fall = ~s2_q & s3_q;
      end else begin : g_level
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: oversampling I2S / left-justified receiver on the system clock.
// Rebuilds stereo words from externally clocked sclk/lrclk/sdata and hands
// each completed left/right pair to the datapath with a one-clk valid.
// clk must run at least 4x the sclk frequency.
//   clk, rst              : system clock, synchronous active-high reset
//   sclk, lrclk, sdata    : asynchronous serial pins (lrclk 0 = left)
//   left_chan, right_chan : last completed pair, MSB-aligned
//   valid                 : one-clk strobe, pair updated
//   frame_err             : sticky word-length error
// Build option: I2S_RX_FRAME_CHECK_EN enables the word-length checker;
// without it frame_err is tied low.
//
// state  | meaning
// -------+--------------------------------------------------------------
// UNSYNC | waiting for the first lrclk transition, data ignored
// RUN    | word-aligned, every sclk rise shifts or completes a word
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int unsigned BITSIZE = BITSIZE_DEF,
   parameter int unsigned LJ      = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sclk,
   input  logic               lrclk,
   input  logic               sdata,
   output logic [BITSIZE-1:0] left_chan,
   output logic [BITSIZE-1:0] right_chan,
   output logic               valid,
   output logic               frame_err
);

   localparam int unsigned     CW       = $clog2(BITSIZE + 1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(BITSIZE);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   logic sclk_lvl_unused, sclk_rise, sclk_fall_unused;
   logic lrclk_s, lr_rise_unused, lr_fall_unused;
   logic sdata_s, sd_rise_unused, sd_fall_unused;

   i2s_sync_edge #(.EDGE_DET(1'b1)) u_sync_sclk (
      .clk  (clk),
      .rst  (rst),
      .din  (sclk),
      .sync (sclk_lvl_unused),
      .rise (sclk_rise),
      .fall (sclk_fall_unused)
   );

   i2s_sync_edge #(.EDGE_DET(1'b0)) u_sync_lrclk (
      .clk  (clk),
      .rst  (rst),
      .din  (lrclk),
      .sync (lrclk_s),
      .rise (lr_rise_unused),
      .fall (lr_fall_unused)
   );

   i2s_sync_edge #(.EDGE_DET(1'b0)) u_sync_sdata (
      .clk  (clk),
      .rst  (rst),
      .din  (sdata),
      .sync (sdata_s),
      .rise (sd_rise_unused),
      .fall (sd_fall_unused)
   );

   // deserializer state
   i2s_state_t          state_q, state_d;
   logic                lr_prev_q, lr_prev_d;
   logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [BITSIZE-1:0]  shreg_q, shreg_d;

   // stage A: completed word
   logic                done_q, done_d;
   logic                done_ch_q, done_ch_d;
   logic [BITSIZE-1:0]  done_word_q, done_word_d;

   // stage B: left/right pairing
   logic [BITSIZE-1:0]  left_hold_q, left_hold_d;
   logic                left_ok_q, left_ok_d;
   logic                pair_q, pair_d;
   logic [BITSIZE-1:0]  pair_l_q, pair_l_d;
   logic [BITSIZE-1:0]  pair_r_q, pair_r_d;

   // stage C: outputs
   logic [BITSIZE-1:0]  left_chan_q, left_chan_d;
   logic [BITSIZE-1:0]  right_chan_q, right_chan_d;
   logic                valid_q, valid_d;

   logic                boundary;
   logic                cnt_full;
   logic [BITSIZE-1:0]  shift_in;
   logic                cmp;
   logic [CW-1:0]       cmp_n;
   logic [BITSIZE-1:0]  cmp_bits;
   logic [BITSIZE-1:0]  cmp_word;

   assign boundary = (lrclk_s != lr_prev_q);
   assign cnt_full = (bit_cnt_q >= CNT_FULL);
   assign shift_in = {shreg_q[BITSIZE-2:0], sdata_s};

   // Only the first BITSIZE bits are ever kept, so n never exceeds BITSIZE
   // here; n = 0 shifts everything out and yields 0.
   assign cmp_word = cmp_bits << (CNT_FULL - cmp_n);

   always_comb begin
      state_d   = state_q;
      lr_prev_d = lr_prev_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      cmp       = 1'b0;
      cmp_n     = bit_cnt_q;
      cmp_bits  = shreg_q;

      if (sclk_rise) begin
         lr_prev_d = lrclk_s;
         if (state_q == UNSYNC) begin
            if (boundary) begin
               state_d   = RUN;
               bit_cnt_d = '0;
               shreg_d   = '0;
            end
         end else if (boundary) begin
            cmp = 1'b1;
            if (LJ == 0) begin
               // Philips: this bit is still the outgoing word's LSB, unless
               // the word is already full, in which case it is dropped.
               if (!cnt_full) begin
                  cmp_bits = shift_in;
                  cmp_n    = bit_cnt_q + CNT_ONE;
               end
               shreg_d   = '0;
               bit_cnt_d = '0;
            end else begin
               // Left-justified: this bit is the incoming word's MSB.
               shreg_d   = {{(BITSIZE-1){1'b0}}, sdata_s};
               bit_cnt_d = CNT_ONE;
            end
         end else if (!cnt_full) begin
            shreg_d   = shift_in;
            bit_cnt_d = bit_cnt_q + CNT_ONE;
         end
      end
   end

   always_comb begin
      done_d      = cmp;
      done_ch_d   = cmp ? lr_prev_q : done_ch_q;
      done_word_d = cmp ? cmp_word  : done_word_q;
   end

   // A right word only goes out if a left word preceded it, which drops the
   // partial frame that follows synchronization.
   always_comb begin
      left_hold_d = left_hold_q;
      left_ok_d   = left_ok_q;
      pair_d      = 1'b0;
      pair_l_d    = pair_l_q;
      pair_r_d    = pair_r_q;
      if (done_q) begin
         if (done_ch_q == CH_RIGHT) begin
            if (left_ok_q) begin
               pair_d    = 1'b1;
               pair_l_d  = left_hold_q;
               pair_r_d  = done_word_q;
               left_ok_d = 1'b0;
            end
         end else begin
            left_hold_d = done_word_q;
            left_ok_d   = 1'b1;
         end
      end
   end

   always_comb begin
      left_chan_d  = pair_q ? pair_l_q : left_chan_q;
      right_chan_d = pair_q ? pair_r_q : right_chan_q;
      valid_d      = pair_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= UNSYNC;
         lr_prev_q    <= 1'b0;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         done_q       <= 1'b0;
         done_ch_q    <= 1'b0;
         done_word_q  <= '0;
         left_hold_q  <= '0;
         left_ok_q    <= 1'b0;
         pair_q       <= 1'b0;
         pair_l_q     <= '0;
         pair_r_q     <= '0;
         left_chan_q  <= '0;
         right_chan_q <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         lr_prev_q    <= lr_prev_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         done_q       <= done_d;
         done_ch_q    <= done_ch_d;
         done_word_q  <= done_word_d;
         left_hold_q  <= left_hold_d;
         left_ok_q    <= left_ok_d;
         pair_q       <= pair_d;
         pair_l_q     <= pair_l_d;
         pair_r_q     <= pair_r_d;
         left_chan_q  <= left_chan_d;
         right_chan_q <= right_chan_d;
         valid_q      <= valid_d;
      end
   end

   assign left_chan  = left_chan_q;
   assign right_chan = right_chan_q;
   assign valid      = valid_q;

`ifdef I2S_RX_FRAME_CHECK_EN
   // ovf marks a word that received more bits than it can hold; the
   // saturated counter alone cannot tell BITSIZE from BITSIZE+k.
   logic ovf_q, ovf_d;
   logic first_q, first_d;
   logic frame_err_q, frame_err_d;
   logic cmp_bad;

   assign cmp_bad = (cmp_n != CNT_FULL) || ovf_q || ((LJ == 0) && cnt_full);

   always_comb begin
      ovf_d       = ovf_q;
      first_d     = first_q;
      frame_err_d = frame_err_q;
      if (sclk_rise && (state_q == UNSYNC) && boundary) begin
         ovf_d   = 1'b0;
         first_d = 1'b1;
      end else if (cmp) begin
         ovf_d   = 1'b0;
         first_d = 1'b0;
         if (!first_q && cmp_bad) frame_err_d = 1'b1;
      end else if (sclk_rise && (state_q == RUN) && cnt_full) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q       <= 1'b0;
         first_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         ovf_q       <= ovf_d;
         first_q     <= first_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign frame_err = frame_err_q;
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
I2S receiver, the companion to the team's I2S transmitter (same BITSIZE, same channel convention: lrclk 0 = left, 1 = right, MSB first).
- Runs on the system clock `clk`, not on `sclk`.
- Oversamples the externally driven sclk/lrclk/sdata pins and rebuilds stereo samples.
- Presents each completed left/right pair as parallel words with a one-cycle `valid` strobe to the audio datapath (DSP/FIFO).
- Requirement: clk ≥ 4× sclk frequency.

Parameters:
- BITSIZE, 32: word width per channel; output width.
- LJ, 0: 0 = Philips I2S (MSB one sclk after lrclk edge); 1 = left-justified (MSB on lrclk edge).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- sclk  in  1  serial bit clock, asynchronous to clk.
- lrclk  in  1  word select, asynchronous.
- sdata  in  1  serial data, asynchronous.
- left_chan  out  BITSIZE  last completed left word.
- right_chan  out  BITSIZE  last completed right word.
- valid  out  1  one-clk pulse: left_chan/right_chan updated as a pair.
- frame_err  out  1  sticky error flag (only with I2S_RX_FRAME_CHECK_EN; else tied 0).

Behaviour:
- Input sync: 2-FF synchronizer per pin, then a third register for edge detect. sclk_rise = stage2 & ~stage3. sdata/lrclk are taken from stage2 in the same cycle as sclk_rise. The transmitter drives on falling edges; we sample on rising edges.
- Reset: left_chan = 0, right_chan = 0, valid = 0, frame_err = 0, bit_cnt = 0, shift register = 0, state = UNSYNC, lr_prev = 0.
- FSM:
  - UNSYNC: ignore data. On the first sclk_rise with lrclk != lr_prev, go to RUN and clear bit_cnt.
  - RUN: process every sclk_rise as below.
- Boundary (sclk_rise with lrclk != lr_prev), LJ=0:
  - The current bit is the LSB of the outgoing word: shift it in, then complete that word for channel lr_prev.
  - New word starts empty.
- Boundary, LJ=1:
  - Complete the outgoing word without the current bit.
  - Current bit becomes the new word's MSB; bit_cnt = 1.
- Non-boundary sclk_rise: if bit_cnt < BITSIZE, shift sdata in at LSB and increment bit_cnt. Otherwise discard the bit; bit_cnt saturates.
- Word completion with n bits:
  - Word = shreg << (BITSIZE − n), i.e. MSB-aligned, zero-padded LSBs.
  - n = 0 gives 0.
  - n > BITSIZE keeps the first BITSIZE bits.
- Channel 0 completion: latch into left holding register; set left_ok.
- Channel 1 completion:
  - If left_ok: update left_chan and right_chan together, pulse valid, clear left_ok.
  - Otherwise discard the word, so the first partial frame after sync never emits.
- lr_prev updates on every sclk_rise.
- Latency: valid asserts exactly 4 clk after the first clk edge that samples the completing sclk rise high on the pin. Outputs are stable until the next valid.
- Simultaneous events: boundary plus bit_cnt saturation → completion wins; the word uses the first BITSIZE bits.
- No sclk activity: outputs hold indefinitely; no timeout.
- rst mid-frame: everything returns to reset values immediately and the block re-enters UNSYNC. The partial frame is dropped.

Optional Feature:
I2S_RX_FRAME_CHECK_EN
- Defined: at each completion in RUN state (excluding the first completion after sync), if n != BITSIZE, set frame_err. frame_err is sticky until rst. Words are still emitted per the rules above.
- Undefined: no checker logic; frame_err is driven constant 0.

Decomposition:
- Shared package i2s_pkg:
  - CH_LEFT = 1'b0 and CH_RIGHT = 1'b1.
  - Default BITSIZE constant.
  - FSM state typedef {UNSYNC, RUN}; the transmitter uses the same channel constants.
- One sub-module, i2s_sync_edge: 3-stage synchronizer with rise/fall outputs, instantiated for sclk. lrclk and sdata use plain 2-FF instances of it.

Test Plan:
- Reset then 3 frames, BITSIZE=32, LJ=0, left=32'hA5A5_0F0F, right=32'h1234_5678 → first frame dropped; frames 2 and 3 give valid with exactly those words, valid width 1 clk.
- Loopback: instantiate i2s_tx driven by the same sclk/lrclk with left=32'hDEAD_BEEF, right=32'h0000_0001 → received pair matches, with a one-frame pipeline offset.
- Short words: 24 bits per half-frame, left=24'hABCDEF, right=24'h123456 → left_chan=32'hABCDEF00, right_chan=32'h12345600. With FRAME_CHECK_EN, frame_err=1.
- Long words: 40 bits per half-frame, first 32 bits = 32'hCAFEF00D → left_chan=32'hCAFEF00D; extra bits ignored.
- LJ=1 with left=32'h8000_0001, right=32'h7FFF_FFFE → exact match; the same stimulus with LJ=0 gives a 1-bit-shifted mismatch.
- Assert rst for 2 clk in the middle of a left word → outputs 0 and valid 0 next cycle; no valid until one full frame after the next lrclk edge.
